// File: rtl/conv_tile_writeback_pkg.sv
// Shared constants and types for the conv tile writeback stage.
// Default tile geometry and word width match the conv array configuration.
// The WB_* encodings pin down the writeback FSM state values.
package conv_tile_writeback_pkg;

  localparam int unsigned CNN_PARA_X     = 3;
  localparam int unsigned CNN_PARA_Y     = 4;
  localparam int unsigned CNN_DATA_WIDTH = 16;
  localparam int unsigned WB_ADDR_WIDTH  = 16;

  localparam logic [0:0] WB_IDLE  = 1'b0;
  localparam logic [0:0] WB_DRAIN = 1'b1;

  typedef enum logic [0:0] {
    WbIdle  = WB_IDLE,
    WbDrain = WB_DRAIN
  } wb_state_e;

endpackage

// File: rtl/conv_tile_writeback_if.sv
// Write port into the output feature-map buffer.
//   wr_en    master -> slave  write request
//   wr_addr  master -> slave  word address
//   wr_data  master -> slave  word data
//   wr_ready slave -> master  buffer accepts; a transfer is wr_en & wr_ready
interface conv_tile_writeback_if
  import conv_tile_writeback_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = WB_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = CNN_DATA_WIDTH
);

  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_ready;

  modport master (
    output wr_en,
    output wr_addr,
    output wr_data,
    input  wr_ready
  );

  modport slave (
    input  wr_en,
    input  wr_addr,
    input  wr_data,
    output wr_ready
  );

endinterface

// File: rtl/conv_tile_addr_gen.sv
// Walks one tile in raster order (x fastest) and produces its write addresses.
//   clk, rst  clock and asynchronous active-low reset
//   load      restart at word 0 with a new base/stride (wins over advance)
//   base      address of word (0,0)
//   stride    address delta between rows
//   advance   step to the next word
//   addr      row_start + x, modulo 2^ADDR_WIDTH
//   k         linear word index y*PARA_X + x
//   last      current word is the final word of the tile
module conv_tile_addr_gen
  import conv_tile_writeback_pkg::*;
#(
  parameter int unsigned PARA_X     = CNN_PARA_X,
  parameter int unsigned PARA_Y     = CNN_PARA_Y,
  parameter int unsigned ADDR_WIDTH = WB_ADDR_WIDTH,
  parameter int unsigned K_WIDTH    = (PARA_X * PARA_Y > 1) ? $clog2(PARA_X * PARA_Y) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [ADDR_WIDTH-1:0] base,
  input  logic [ADDR_WIDTH-1:0] stride,
  input  logic                  advance,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [K_WIDTH-1:0]    k,
  output logic                  last
);

  localparam int unsigned XW = (PARA_X > 1) ? $clog2(PARA_X) : 1;
  localparam int unsigned YW = (PARA_Y > 1) ? $clog2(PARA_Y) : 1;

  logic [XW-1:0]         x_q, x_d;
  logic [YW-1:0]         y_q, y_d;
  logic [ADDR_WIDTH-1:0] row_start_q, row_start_d;
  logic [ADDR_WIDTH-1:0] stride_q, stride_d;
  logic                  x_end, y_end;

  assign x_end = (x_q == XW'(PARA_X - 1));
  assign y_end = (y_q == YW'(PARA_Y - 1));

  always_comb begin
    x_d         = x_q;
    y_d         = y_q;
    row_start_d = row_start_q;
    stride_d    = stride_q;
    if (load) begin
      x_d         = '0;
      y_d         = '0;
      row_start_d = base;
      stride_d    = stride;
    end else if (advance) begin
      if (x_end) begin
        x_d = '0;
        if (y_end) begin
          y_d = '0;
        end else begin
          y_d         = y_q + YW'(1);
          // Incremental row address; wraps silently.
          row_start_d = row_start_q + stride_q;
        end
      end else begin
        x_d = x_q + XW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_q         <= '0;
      y_q         <= '0;
      row_start_q <= '0;
      stride_q    <= '0;
    end else begin
      x_q         <= x_d;
      y_q         <= y_d;
      row_start_q <= row_start_d;
      stride_q    <= stride_d;
    end
  end

  assign addr = row_start_q + ADDR_WIDTH'(x_q);
  assign k    = K_WIDTH'(32'(y_q) * PARA_X + 32'(x_q));
  assign last = x_end & y_end;

endmodule

// File: rtl/conv_tile_writeback.sv
// Captures finished conv result tiles into a two-entry FIFO and drains them
// word by word into the output feature-map buffer write port.
//   clk, rst       clock and asynchronous active-low reset
//   result_ready   level tile-valid; its rising edge captures a tile
//   result_buffer  tile words, word k at [k*DATA_WIDTH +: DATA_WIDTH]
//   tile_base      address of word (0,0), sampled at capture
//   row_stride     address delta between rows, sampled at capture
//   clr_overflow   synchronous clear of overflow
//   wr             write port (master side)
//   tile_done      pulse on the final word's transfer
//   busy           any slot occupied
//   overflow       sticky: a capture was dropped
module conv_tile_writeback
  import conv_tile_writeback_pkg::*;
#(
  parameter int unsigned PARA_X     = CNN_PARA_X,
  parameter int unsigned PARA_Y     = CNN_PARA_Y,
  parameter int unsigned DATA_WIDTH = CNN_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = WB_ADDR_WIDTH
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                result_ready,
  input  logic [PARA_X*PARA_Y*DATA_WIDTH-1:0] result_buffer,
  input  logic [ADDR_WIDTH-1:0]               tile_base,
  input  logic [ADDR_WIDTH-1:0]               row_stride,
  input  logic                                clr_overflow,
  conv_tile_writeback_if.master               wr,
  output logic                                tile_done,
  output logic                                busy,
  output logic                                overflow
);

  localparam int unsigned TILE_BITS = PARA_X * PARA_Y * DATA_WIDTH;
  localparam int unsigned K_WIDTH   = (PARA_X * PARA_Y > 1) ? $clog2(PARA_X * PARA_Y) : 1;

  logic                  result_ready_q;
  logic [TILE_BITS-1:0]  slot_data_q   [2];
  logic [ADDR_WIDTH-1:0] slot_base_q   [2];
  logic [ADDR_WIDTH-1:0] slot_stride_q [2];
  logic [1:0]            full_q, full_d;
  logic                  wr_ptr_q, wr_ptr_d;
  logic                  rd_ptr_q, rd_ptr_d;
  wb_state_e             state_q, state_d;
  logic                  overflow_q, overflow_d;

  logic                  capture, accept, drop;
  logic                  draining, xfer, final_xfer;
  logic                  ag_load;
  logic [ADDR_WIDTH-1:0] ag_base, ag_stride, ag_addr;
  logic [K_WIDTH-1:0]    ag_k;
  logic                  ag_last;

  assign capture    = result_ready & ~result_ready_q;
  assign draining   = (state_q == WbDrain);
  assign xfer       = draining & wr.wr_ready;
  assign final_xfer = xfer & ag_last;
  // With both slots full the write slot is the head; it frees only on its final transfer.
  assign accept     = capture & (~full_q[wr_ptr_q] | (final_xfer & (wr_ptr_q == rd_ptr_q)));
  assign drop       = capture & ~accept;

  always_comb begin
    full_d = full_q;
    if (final_xfer) full_d[rd_ptr_q] = 1'b0;
    if (accept)     full_d[wr_ptr_q] = 1'b1;
    wr_ptr_d = accept     ? ~wr_ptr_q : wr_ptr_q;
    rd_ptr_d = final_xfer ? ~rd_ptr_q : rd_ptr_q;

    overflow_d = overflow_q;
    if (drop)              overflow_d = 1'b1;
    else if (clr_overflow) overflow_d = 1'b0;
  end

  // Next head's base/stride: bypass from the inputs when it is being captured now.
  always_comb begin
    if (accept && (wr_ptr_q == rd_ptr_d)) begin
      ag_base   = tile_base;
      ag_stride = row_stride;
    end else begin
      ag_base   = slot_base_q[rd_ptr_d];
      ag_stride = slot_stride_q[rd_ptr_d];
    end
  end

  always_comb begin
    state_d = state_q;
    ag_load = 1'b0;
    unique case (state_q)
      WbIdle: begin
        if (full_d[rd_ptr_d]) begin
          state_d = WbDrain;
          ag_load = 1'b1;
        end
      end
      WbDrain: begin
        if (final_xfer) begin
          // Back-to-back tiles: load the next head so its word 0 follows without a bubble.
          if (full_d[rd_ptr_d]) ag_load = 1'b1;
          else                  state_d = WbIdle;
        end
      end
      default: state_d = WbIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      result_ready_q <= 1'b0;
      full_q         <= '0;
      wr_ptr_q       <= 1'b0;
      rd_ptr_q       <= 1'b0;
      state_q        <= WbIdle;
      overflow_q     <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        slot_data_q[i]   <= '0;
        slot_base_q[i]   <= '0;
        slot_stride_q[i] <= '0;
      end
    end else begin
      result_ready_q <= result_ready;
      full_q         <= full_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      state_q        <= state_d;
      overflow_q     <= overflow_d;
      if (accept) begin
        slot_data_q[wr_ptr_q]   <= result_buffer;
        slot_base_q[wr_ptr_q]   <= tile_base;
        slot_stride_q[wr_ptr_q] <= row_stride;
      end
    end
  end

  conv_tile_addr_gen #(
    .PARA_X     (PARA_X),
    .PARA_Y     (PARA_Y),
    .ADDR_WIDTH (ADDR_WIDTH),
    .K_WIDTH    (K_WIDTH)
  ) u_addr_gen (
    .clk     (clk),
    .rst     (rst),
    .load    (ag_load),
    .base    (ag_base),
    .stride  (ag_stride),
    .advance (xfer),
    .addr    (ag_addr),
    .k       (ag_k),
    .last    (ag_last)
  );

  assign wr.wr_en   = draining;
  assign wr.wr_addr = draining ? ag_addr : '0;
  assign wr.wr_data = draining ? slot_data_q[rd_ptr_q][32'(ag_k) * DATA_WIDTH +: DATA_WIDTH]
                               : '0;
  assign tile_done  = final_xfer;
  assign busy       = |full_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_conv_tile_writeback.sv
module tb_conv_tile_writeback;
  import conv_tile_writeback_pkg::*;

  localparam int unsigned PX = 3;
  localparam int unsigned PY = 4;
  localparam int unsigned DW = 16;
  localparam int unsigned AW = 16;
  localparam int unsigned NW = PX * PY;

  logic              clk = 1'b0;
  logic              rst;
  logic              result_ready;
  logic [NW*DW-1:0]  result_buffer;
  logic [AW-1:0]     tile_base;
  logic [AW-1:0]     row_stride;
  logic              clr_overflow;
  logic              tile_done;
  logic              busy;
  logic              overflow;

  conv_tile_writeback_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) wr_bus ();

  conv_tile_writeback #(
    .PARA_X     (PX),
    .PARA_Y     (PY),
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .result_ready  (result_ready),
    .result_buffer (result_buffer),
    .tile_base     (tile_base),
    .row_stride    (row_stride),
    .clr_overflow  (clr_overflow),
    .wr            (wr_bus),
    .tile_done     (tile_done),
    .busy          (busy),
    .overflow      (overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          done;
  } wr_t;

  wr_t           exp_q[$];
  wr_t           obs_q[$];
  int            obs_cyc[$];
  int            checks = 0;
  int            passed = 0;
  int            fails  = 0;
  int            cyc    = 0;
  int            rdy_mode  = 0;  // 0: always 1, 1: 1,0,0 pattern, 2: random, 3: always 0
  int            rdy_phase = 0;
  logic [DW-1:0] words [NW];

  logic          prev_stall = 1'b0;
  logic [AW-1:0] prev_addr;
  logic [DW-1:0] prev_data;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       wr_bus.wr_ready = 1'b1;
      1: begin
        wr_bus.wr_ready = (rdy_phase % 3 == 0);
        rdy_phase++;
      end
      2:       wr_bus.wr_ready = 1'($urandom_range(0, 1));
      default: wr_bus.wr_ready = 1'b0;
    endcase
  end

  // Transfer recorder; also checks that a stalled request is held unchanged.
  always @(negedge clk) begin
    if (!rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_hold_en", 64'(wr_bus.wr_en), 64'd1);
        check("stall_hold_addr", 64'(wr_bus.wr_addr), 64'(prev_addr));
        check("stall_hold_data", 64'(wr_bus.wr_data), 64'(prev_data));
      end
      if (tile_done) check("done_needs_xfer", 64'(wr_bus.wr_en & wr_bus.wr_ready), 64'd1);
      if (wr_bus.wr_en && wr_bus.wr_ready) begin
        obs_q.push_back('{addr: wr_bus.wr_addr, data: wr_bus.wr_data, done: tile_done});
        obs_cyc.push_back(cyc);
      end
      prev_stall = wr_bus.wr_en && !wr_bus.wr_ready;
      prev_addr  = wr_bus.wr_addr;
      prev_data  = wr_bus.wr_data;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  task automatic rand_words();
    for (int k = 0; k < NW; k++) words[k] = DW'($urandom);
  endtask

  // Reference: raster order, address = base + y*stride + x modulo 2^AW.
  task automatic push_tile(input logic [AW-1:0] base, input logic [AW-1:0] stride,
                           input int nwords);
    for (int k = 0; k < nwords; k++) begin
      wr_t e;
      e.addr = base + AW'(k / PX) * stride + AW'(k % PX);
      e.data = words[k];
      e.done = (k == NW - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic present(input logic [AW-1:0] base, input logic [AW-1:0] stride);
    for (int k = 0; k < NW; k++) result_buffer[k*DW +: DW] = words[k];
    tile_base    = base;
    row_stride   = stride;
    result_ready = 1'b1;
  endtask

  task automatic capture(input logic [AW-1:0] base, input logic [AW-1:0] stride,
                         input int hold, input bit accepted);
    present(base, stride);
    if (accepted) push_tile(base, stride, NW);
    repeat (hold) step();
    result_ready = 1'b0;
    step();
  endtask

  task automatic wait_obs(input int n);
    for (int i = 0; i < 800 && obs_q.size() < n; i++) sample();
  endtask

  task automatic compare(input string tag);
    int n;
    wait_obs(exp_q.size());
    repeat (4) sample();
    check({tag, "_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check($sformatf("%s[%0d]", tag, i), 64'(obs_q[i]), 64'(exp_q[i]));
  endtask

  task automatic clear_queues();
    exp_q.delete();
    obs_q.delete();
    obs_cyc.delete();
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 800 && busy !== 1'b0; i++) sample();
    check(tag, 64'(busy), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst             = 1'b0;
    result_ready    = 1'b0;
    result_buffer   = '0;
    tile_base       = '0;
    row_stride      = '0;
    clr_overflow    = 1'b0;
    wr_bus.wr_ready = 1'b1;
    #3;
    check("rst_wr_en", 64'(wr_bus.wr_en), 64'd0);
    check("rst_wr_addr", 64'(wr_bus.wr_addr), 64'd0);
    check("rst_wr_data", 64'(wr_bus.wr_data), 64'd0);
    check("rst_tile_done", 64'(tile_done), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    step();
    step();
    rst = 1'b1;
    step();

    // Directed single tile with a one-cycle capture-to-write latency.
    words = '{16'h4400, 16'h4b80, 16'h4c00, 16'h4c80, 16'h4d00, 16'h4d80,
              16'h4e00, 16'h4e80, 16'h4f00, 16'h4f80, 16'h5000, 16'h5060};
    present(16'h0100, 16'h0010);
    push_tile(16'h0100, 16'h0010, NW);
    check("lat_before_edge", 64'(wr_bus.wr_en), 64'd0);
    step();
    result_ready = 1'b0;
    check("lat_wr_en", 64'(wr_bus.wr_en), 64'd1);
    check("lat_first_addr", 64'(wr_bus.wr_addr), 64'h0100);
    check("lat_first_data", 64'(wr_bus.wr_data), 64'h4400);
    wait_obs(NW);
    sample();
    check("t1_busy_after", 64'(busy), 64'd0);
    check("t1_wr_en_after", 64'(wr_bus.wr_en), 64'd0);
    compare("t1");
    clear_queues();

    // Backpressure pattern 1,0,0.
    rdy_phase = 0;
    rdy_mode  = 1;
    capture(16'h0100, 16'h0010, 1, 1'b1);
    compare("bp");
    clear_queues();
    rdy_mode = 0;
    wait_idle("bp_idle");

    // Level held high: one capture only.
    rand_words();
    present(16'h0a00, 16'h0040);
    push_tile(16'h0a00, 16'h0040, NW);
    repeat (20) step();
    result_ready = 1'b0;
    step();
    compare("hold");
    clear_queues();
    check("hold_overflow", 64'(overflow), 64'd0);

    // Three edges while stalled: third is dropped.
    rdy_mode = 3;
    step();
    rand_words();
    capture(16'h2000, 16'h0008, 1, 1'b1);
    rand_words();
    capture(16'h3000, 16'h0100, 1, 1'b1);
    rand_words();
    capture(16'h4000, 16'h0005, 1, 1'b0);
    sample();
    check("drop_overflow", 64'(overflow), 64'd1);
    check("drop_busy", 64'(busy), 64'd1);
    check("drop_wr_en", 64'(wr_bus.wr_en), 64'd1);
    check("drop_head_addr", 64'(wr_bus.wr_addr), 64'h2000);
    // Drop and clear in the same cycle: the drop wins.
    step();
    rand_words();
    present(16'h5000, 16'h0001);
    clr_overflow = 1'b1;
    step();
    clr_overflow = 1'b0;
    result_ready = 1'b0;
    step();
    check("drop_beats_clr", 64'(overflow), 64'd1);
    rdy_mode = 0;
    wait_obs(2 * NW);
    if (obs_cyc.size() > NW) check("no_bubble", 64'(obs_cyc[NW] - obs_cyc[NW-1]), 64'd1);
    compare("drop");
    clear_queues();
    step();
    clr_overflow = 1'b1;
    step();
    clr_overflow = 1'b0;
    sample();
    check("clr_overflow", 64'(overflow), 64'd0);

    // Address wrap past the top of the space.
    rand_words();
    capture(16'hfffe, 16'h0003, 1, 1'b1);
    compare("wrap");
    clear_queues();

    // Randomised pairs of tiles under random backpressure.
    for (int it = 0; it < 6; it++) begin
      rdy_mode = 2;
      rand_words();
      capture(AW'($urandom), AW'($urandom), $urandom_range(1, 3), 1'b1);
      repeat ($urandom_range(0, 4)) step();
      rand_words();
      capture(AW'($urandom), AW'($urandom), $urandom_range(1, 3), 1'b1);
      compare($sformatf("rnd%0d", it));
      clear_queues();
      rdy_mode = 0;
      wait_idle($sformatf("rnd%0d_idle", it));
    end

    // Reset mid-drain with a second tile queued.
    rdy_mode = 0;
    step();
    rand_words();
    present(16'h0800, 16'h0020);
    push_tile(16'h0800, 16'h0020, 5);
    step();
    result_ready = 1'b0;
    step();
    rand_words();
    capture(16'h0900, 16'h0020, 1, 1'b0);
    wait_obs(5);
    step();
    rst = 1'b0;
    #1;
    check("midrst_wr_en", 64'(wr_bus.wr_en), 64'd0);
    check("midrst_wr_addr", 64'(wr_bus.wr_addr), 64'd0);
    check("midrst_wr_data", 64'(wr_bus.wr_data), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_tile_done", 64'(tile_done), 64'd0);
    step();
    step();
    rst = 1'b1;
    repeat (30) step();
    compare("midrst");
    clear_queues();
    check("midrst_busy_after", 64'(busy), 64'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
